dram_ddr_pad_rptr_pipe: RTL
===========================

Name:
dram_ddr_pad_rptr_pipe

Overview:
Parametrised, registered DRAM-to-DDR-pad repeater with independent outbound (controller->pad) and inbound (pad->controller) pipelines of configurable depth.
Adds channel-disable command gating, valid-qualified inbound data capture and a saturating inbound beat counter, for long south/north routes that need retiming.

Parameters:
ADDR_W, 15, DRAM address width
DOUT_W, 288, outbound write data width (data+ECC)
DIN_W, 256, inbound read data width
ECC_W, 32, inbound ECC width
OUT_STAGES, 2, outbound flop stages (legal 1..4)
IN_STAGES, 2, inbound flop stages (legal 1..4)
CNT_W, 16, beat counter width

Ports:
clk  in  1  core clock
arst_l  in  1  asynchronous active-low reset
dram_io_ctl  in  9  [0]cas_l [1]ras_l [2]write_en_l [3]cke [4]clk_enable [5]drive_data [6]drive_enable [7]pad_enable [8]pad_clk_inv
dram_io_addr  in  ADDR_W  address
dram_io_bank  in  3  bank
dram_io_cs_l  in  4  chip selects, active low
dram_io_data_out  in  DOUT_W  write data
dram_io_ptr_clk_inv  in  5  pointer clock invert controls
dram_io_channel_disabled  in  1  channel disable
io_dram_data_valid  in  1  inbound beat valid
io_dram_data_in  in  DIN_W  inbound data
io_dram_ecc_in  in  ECC_W  inbound ECC
stat_clr  in  1  synchronous beat-counter clear
dram_io_ctl_buf  out  9  retimed/gated ctl
dram_io_addr_buf  out  ADDR_W  retimed address
dram_io_bank_buf  out  3  retimed bank
dram_io_cs_l_buf  out  4  retimed/gated chip selects
dram_io_data_out_buf  out  DOUT_W  retimed write data
dram_io_ptr_clk_inv_buf  out  5  retimed ptr clk inv
dram_io_channel_disabled_buf  out  1  retimed disable
io_dram_data_valid_buf  out  1  retimed inbound valid
io_dram_data_in_buf  out  DIN_W  retimed inbound data
io_dram_ecc_in_buf  out  ECC_W  retimed inbound ECC
stat_beat_cnt  out  CNT_W  inbound beats delivered

Behaviour:
- Clock/reset: single clk; reset is asynchronous and active-low (arst_l); all flops of every stage reset immediately on arst_l=0, no partial state survives; release is clean on next clk edge.
- Reset values: ctl_buf=9'h007 (cas_l/ras_l/write_en_l high, rest 0); cs_l_buf=4'hF; channel_disabled_buf=1; addr/bank/data_out/ptr_clk_inv bufs=0; valid_buf=0; data_in/ecc bufs=0; stat_beat_cnt=0.
- Outbound latency exactly OUT_STAGES cycles for every output incl. channel_disabled_buf; full throughput, one beat per cycle, no stalls.
- Gating applied at stage-1 input using unregistered dram_io_channel_disabled: when 1, stage-1 ctl[7:0]=8'h07, cs_l=4'hF; addr/bank/data_out stage-1 regs hold (no toggle); ctl[8] and ptr_clk_inv pass ungated.
- Inbound valid pipelined every cycle, latency IN_STAGES; stage-1 valid forced 0 while dram_io_channel_disabled=1.
- Inbound data/ECC stage regs load only when their incoming valid=1, else hold; data_in_buf/ecc_in_buf aligned with valid_buf and hold last delivered beat.
- stat_beat_cnt +1 per cycle io_dram_data_valid_buf=1; saturates at all-ones (no wrap); stat_clr=1 -> 0 next cycle, priority over coincident increment.
- OUT_STAGES/IN_STAGES outside 1..4: elaboration must fail.

Test Plan:
- arst_l low mid-traffic -> same-cycle reset values: cs_l_buf=4'hF, ctl_buf=9'h007, channel_disabled_buf=1, stat_beat_cnt=0.
- OUT_STAGES=2, addr=15'h1234, cs_l=4'hE, ctl=9'h0F6 at cycle 0, new values each cycle -> each appears unchanged at cycle+2, back-to-back.
- channel_disabled=1 with cs_l=4'h0, ctl=9'h1F8 -> after OUT_STAGES cs_l_buf=4'hF, ctl_buf=9'h107, addr_buf holds last enabled value.
- IN_STAGES=3, valid at cycles 0,1,3 with D0,D1,D2 -> valid_buf at 3,4,6; data_in_buf=D1 at cycle 5; disable during beat -> beat dropped, not counted.
- CNT_W=4, 17 beats -> stat_beat_cnt=4'hF held; stat_clr coincident with beat -> 0.

Source files
------------

// File: rtl/dram_ddr_pad_rptr_pipe_if.sv
// Signal bundle between the DRAM controller side and the DDR pad repeater.
// The repeater uses the slave modport; the controller/pad side uses master.
interface dram_ddr_pad_rptr_pipe_if #(
   parameter int ADDR_W = 15,
   parameter int DOUT_W = 288,
   parameter int DIN_W  = 256,
   parameter int ECC_W  = 32,
   parameter int CNT_W  = 16
);
   logic [8:0]        dram_io_ctl;
   logic [ADDR_W-1:0] dram_io_addr;
   logic [2:0]        dram_io_bank;
   logic [3:0]        dram_io_cs_l;
   logic [DOUT_W-1:0] dram_io_data_out;
   logic [4:0]        dram_io_ptr_clk_inv;
   logic              dram_io_channel_disabled;
   logic              io_dram_data_valid;
   logic [DIN_W-1:0]  io_dram_data_in;
   logic [ECC_W-1:0]  io_dram_ecc_in;
   logic              stat_clr;

   logic [8:0]        dram_io_ctl_buf;
   logic [ADDR_W-1:0] dram_io_addr_buf;
   logic [2:0]        dram_io_bank_buf;
   logic [3:0]        dram_io_cs_l_buf;
   logic [DOUT_W-1:0] dram_io_data_out_buf;
   logic [4:0]        dram_io_ptr_clk_inv_buf;
   logic              dram_io_channel_disabled_buf;
   logic              io_dram_data_valid_buf;
   logic [DIN_W-1:0]  io_dram_data_in_buf;
   logic [ECC_W-1:0]  io_dram_ecc_in_buf;
   logic [CNT_W-1:0]  stat_beat_cnt;

   modport master (
      output dram_io_ctl, dram_io_addr, dram_io_bank, dram_io_cs_l,
             dram_io_data_out, dram_io_ptr_clk_inv, dram_io_channel_disabled,
             io_dram_data_valid, io_dram_data_in, io_dram_ecc_in, stat_clr,
      input  dram_io_ctl_buf, dram_io_addr_buf, dram_io_bank_buf, dram_io_cs_l_buf,
             dram_io_data_out_buf, dram_io_ptr_clk_inv_buf, dram_io_channel_disabled_buf,
             io_dram_data_valid_buf, io_dram_data_in_buf, io_dram_ecc_in_buf, stat_beat_cnt
   );

   modport slave (
      input  dram_io_ctl, dram_io_addr, dram_io_bank, dram_io_cs_l,
             dram_io_data_out, dram_io_ptr_clk_inv, dram_io_channel_disabled,
             io_dram_data_valid, io_dram_data_in, io_dram_ecc_in, stat_clr,
      output dram_io_ctl_buf, dram_io_addr_buf, dram_io_bank_buf, dram_io_cs_l_buf,
             dram_io_data_out_buf, dram_io_ptr_clk_inv_buf, dram_io_channel_disabled_buf,
             io_dram_data_valid_buf, io_dram_data_in_buf, io_dram_ecc_in_buf, stat_beat_cnt
   );
endinterface

// File: rtl/dram_ddr_pad_rptr_pipe.sv
// Registered DRAM<->DDR pad repeater: independent outbound/inbound flop pipelines,
// channel-disable command gating and a saturating delivered-beat counter.
module dram_ddr_pad_rptr_pipe #(
   parameter int ADDR_W     = 15,
   parameter int DOUT_W     = 288,
   parameter int DIN_W      = 256,
   parameter int ECC_W      = 32,
   parameter int OUT_STAGES = 2,
   parameter int IN_STAGES  = 2,
   parameter int CNT_W      = 16
) (
   input logic                     clk,
   input logic                     arst_l,
   dram_ddr_pad_rptr_pipe_if.slave bus
);

   generate
      if (OUT_STAGES < 1 || OUT_STAGES > 4) begin : gBadOutStages
         $error("OUT_STAGES must be within 1..4");
      end
      if (IN_STAGES < 1 || IN_STAGES > 4) begin : gBadInStages
         $error("IN_STAGES must be within 1..4");
      end
   endgenerate

   localparam logic [8:0] CTL_IDLE = 9'h007;

   logic [OUT_STAGES-1:0][8:0]        ctl_q;
   logic [OUT_STAGES-1:0][3:0]        csL_q;
   logic [OUT_STAGES-1:0][ADDR_W-1:0] addr_q;
   logic [OUT_STAGES-1:0][2:0]        bank_q;
   logic [OUT_STAGES-1:0][DOUT_W-1:0] dataOut_q;
   logic [OUT_STAGES-1:0][4:0]        ptrClkInv_q;
   logic [OUT_STAGES-1:0]             chanDis_q;

   logic [8:0]        ctl_d;
   logic [3:0]        csL_d;
   logic [ADDR_W-1:0] addr_d;
   logic [2:0]        bank_d;
   logic [DOUT_W-1:0] dataOut_d;

   logic [IN_STAGES-1:0]             valid_q;
   logic [IN_STAGES-1:0][DIN_W-1:0]  dataIn_q;
   logic [IN_STAGES-1:0][ECC_W-1:0]  ecc_q;
   logic                             validIn_d;

   logic [CNT_W-1:0] beatCnt_q;

   // A disabled channel parks the command bus idle and freezes addr/data so the pads stop toggling.
   always_comb begin
      ctl_d     = bus.dram_io_ctl;
      csL_d     = bus.dram_io_cs_l;
      addr_d    = bus.dram_io_addr;
      bank_d    = bus.dram_io_bank;
      dataOut_d = bus.dram_io_data_out;
      validIn_d = bus.io_dram_data_valid & ~bus.dram_io_channel_disabled;
      if (bus.dram_io_channel_disabled) begin
         ctl_d     = {bus.dram_io_ctl[8], CTL_IDLE[7:0]};
         csL_d     = 4'hF;
         addr_d    = addr_q[0];
         bank_d    = bank_q[0];
         dataOut_d = dataOut_q[0];
      end
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         for (int i = 0; i < OUT_STAGES; i++) begin
            ctl_q[i]       <= CTL_IDLE;
            csL_q[i]       <= 4'hF;
            addr_q[i]      <= '0;
            bank_q[i]      <= '0;
            dataOut_q[i]   <= '0;
            ptrClkInv_q[i] <= '0;
            chanDis_q[i]   <= 1'b1;
         end
      end else begin
         ctl_q[0]       <= ctl_d;
         csL_q[0]       <= csL_d;
         addr_q[0]      <= addr_d;
         bank_q[0]      <= bank_d;
         dataOut_q[0]   <= dataOut_d;
         ptrClkInv_q[0] <= bus.dram_io_ptr_clk_inv;
         chanDis_q[0]   <= bus.dram_io_channel_disabled;
         for (int i = 1; i < OUT_STAGES; i++) begin
            ctl_q[i]       <= ctl_q[i-1];
            csL_q[i]       <= csL_q[i-1];
            addr_q[i]      <= addr_q[i-1];
            bank_q[i]      <= bank_q[i-1];
            dataOut_q[i]   <= dataOut_q[i-1];
            ptrClkInv_q[i] <= ptrClkInv_q[i-1];
            chanDis_q[i]   <= chanDis_q[i-1];
         end
      end
   end

   // Each inbound data stage only loads alongside a valid beat, so the output holds the last delivered beat.
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         valid_q  <= '0;
         dataIn_q <= '0;
         ecc_q    <= '0;
      end else begin
         valid_q[0] <= validIn_d;
         if (validIn_d) begin
            dataIn_q[0] <= bus.io_dram_data_in;
            ecc_q[0]    <= bus.io_dram_ecc_in;
         end
         for (int i = 1; i < IN_STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            if (valid_q[i-1]) begin
               dataIn_q[i] <= dataIn_q[i-1];
               ecc_q[i]    <= ecc_q[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         beatCnt_q <= '0;
      end else if (bus.stat_clr) begin
         beatCnt_q <= '0;
      end else if (valid_q[IN_STAGES-1] && !(&beatCnt_q)) begin
         beatCnt_q <= beatCnt_q + 1'b1;
      end
   end

   assign bus.dram_io_ctl_buf              = ctl_q[OUT_STAGES-1];
   assign bus.dram_io_addr_buf             = addr_q[OUT_STAGES-1];
   assign bus.dram_io_bank_buf             = bank_q[OUT_STAGES-1];
   assign bus.dram_io_cs_l_buf             = csL_q[OUT_STAGES-1];
   assign bus.dram_io_data_out_buf         = dataOut_q[OUT_STAGES-1];
   assign bus.dram_io_ptr_clk_inv_buf      = ptrClkInv_q[OUT_STAGES-1];
   assign bus.dram_io_channel_disabled_buf = chanDis_q[OUT_STAGES-1];
   assign bus.io_dram_data_valid_buf       = valid_q[IN_STAGES-1];
   assign bus.io_dram_data_in_buf          = dataIn_q[IN_STAGES-1];
   assign bus.io_dram_ecc_in_buf           = ecc_q[IN_STAGES-1];
   assign bus.stat_beat_cnt                = beatCnt_q;

endmodule
